// File: rtl/mem_stage_bridge.sv
// ---------------------------------------------------------------------------
// mem_stage_bridge
//
// Purpose:
//   Connects the pipeline memory stage to a variable-latency external data
//   bus through a req/ready handshake. It stalls the pipeline while an access
//   is in flight. It returns load data on ReadDataM in the single release
//   cycle (DONE). It replaces a single-cycle data memory when data memory is
//   off-core.
//
// Ports:
//   clk          in   1      system clock, rising edge
//   reset        in   1      asynchronous, active-low reset
//   MemReadM     in   1      load in memory stage
//   MemWriteM    in   1      store in memory stage (wins over MemReadM)
//   ALUOutM      in   WIDTH  byte address
//   WriteDataM   in   WIDTH  store data
//   ReadDataM    out  WIDTH  load data, registered
//   StallM       out  1      freeze F/D/E/M pipeline registers
//   BusErr       out  1      one-cycle pulse: misaligned access or timeout
//   mem_req      out  1      bus request, registered
//   mem_we       out  1      1=write, 0=read; valid while mem_req
//   mem_addr     out  WIDTH  word-aligned address; valid while mem_req
//   mem_wdata    out  WIDTH  write data; valid while mem_req
//   mem_ready    in   1      bus completes the access when high with mem_req
//   mem_rdata    in   WIDTH  read data, sampled with mem_ready
//   o_dbg_state  out  2      current FSM state (IDLE=0, BUSY=1, DONE=2)
//
// Handshake: mem_req rises on the edge that leaves IDLE. While it is high,
// mem_we, mem_addr and mem_wdata do not change. A transfer completes on the
// first rising edge where mem_req and mem_ready are both high. mem_req then
// drops on that same edge. mem_ready is ignored outside BUSY.
// ---------------------------------------------------------------------------
module mem_stage_bridge #(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             MemReadM,
    input  logic             MemWriteM,
    input  logic [WIDTH-1:0] ALUOutM,
    input  logic [WIDTH-1:0] WriteDataM,
    output logic [WIDTH-1:0] ReadDataM,
    output logic             StallM,
    output logic             BusErr,
    output logic             mem_req,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic             mem_ready,
    input  logic [WIDTH-1:0] mem_rdata,
    output logic [1:0]       o_dbg_state
);

    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] BUSY = 2'b01;
    localparam logic [1:0] DONE = 2'b10;

    // The counter only needs to reach TIMEOUT-1.
    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    logic [1:0]       r_state;
    logic [CW-1:0]    r_cnt;
    logic             r_req;
    logic             r_we;
    logic [WIDTH-1:0] r_addr;
    logic [WIDTH-1:0] r_wdata;
    logic [WIDTH-1:0] r_rdata;
    logic             r_bus_err;

    logic             w_access;
    logic             w_aligned;
    logic             w_start;

    assign w_access  = MemReadM | MemWriteM;
    assign w_aligned = (ALUOutM[1:0] == 2'b00);
    assign w_start   = w_access && w_aligned;

    // The IDLE-detect cycle stalls combinationally. Otherwise the pipeline
    // would advance past the access before the request is even issued.
    // Reset gating keeps every output at 0 while reset is low.
    always_comb begin
        StallM = 1'b0;
        if (reset) begin
            if (r_state == BUSY)
                StallM = 1'b1;
            else if (r_state == IDLE && w_start)
                StallM = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_req     <= 1'b0;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_rdata   <= '0;
            r_bus_err <= 1'b0;
        end else begin
            // BusErr is a single-cycle pulse unless a branch below re-arms it.
            r_bus_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_access) begin
                        if (w_aligned) begin
                            r_req   <= 1'b1;
                            r_we    <= MemWriteM;
                            r_addr  <= {ALUOutM[WIDTH-1:2], 2'b00};
                            r_wdata <= WriteDataM;
                            r_cnt   <= '0;
                            r_state <= BUSY;
                        end else begin
                            // Misaligned: no request, no stall, the pipeline moves on.
                            r_bus_err <= 1'b1;
                        end
                    end
                end
                BUSY: begin
                    // Ready is checked first. A ready on the timeout edge
                    // therefore counts as a success.
                    if (mem_ready) begin
                        if (!r_we)
                            r_rdata <= mem_rdata;
                        r_req   <= 1'b0;
                        r_cnt   <= '0;
                        r_state <= DONE;
                    end else if (r_cnt == CNT_LAST) begin
                        if (!r_we)
                            r_rdata <= '0;
                        r_req     <= 1'b0;
                        r_bus_err <= 1'b1;
                        r_cnt     <= '0;
                        r_state   <= DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                DONE: begin
                    // The stalled instruction is still presented in this
                    // cycle. Its request bits are ignored so it is not reissued.
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign ReadDataM   = r_rdata;
    assign BusErr      = r_bus_err;
    assign mem_req     = r_req;
    assign mem_we      = r_we;
    assign mem_addr    = r_addr;
    assign mem_wdata   = r_wdata;
    assign o_dbg_state = r_state;

endmodule
